// File: rtl/instr_fetch_unit_if.sv
// Unified-memory req/ack bus between the fetch unit (master) and memory (slave).
// Request fields are held stable by the master until mem_ack is sampled high.
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns PC/OldPC/IR/MDR, issues one req/ack memory transaction per strobe; busy stalls the FSM until ack.
// Request on the edge after a strobe, results on the ack edge; optional alignment trap with MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ir_write,
    input  logic                pc_update,
    input  logic                branch,
    input  logic                zero,
    input  logic                data_read,
    input  logic                mem_write,
    input  logic [XLEN-1:0]     pc_next,
    input  logic [XLEN-1:0]     alu_out,
    input  logic [XLEN-1:0]     store_data,
    instr_fetch_unit_if.master  mem,
    output logic [XLEN-1:0]     pc,
    output logic [XLEN-1:0]     old_pc,
    output logic [31:0]         instr,
    output logic [6:0]          opcode,
    output logic [XLEN-1:0]     data_reg,
`ifdef MISALIGN_TRAP_EN
    output logic                misaligned,
`endif
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, FETCH_WAIT, LOAD_WAIT, STORE_WAIT} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, old_pc_q, old_pc_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            req_q, req_d, we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            pend_vld_q, pend_vld_d;

`ifdef MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    logic fetch_mis, data_mis;
    assign fetch_mis = (pc_q[1:0] != 2'b00);
    assign data_mis  = (alu_out[1:0] != 2'b00);
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        old_pc_d   = old_pc_q;
        instr_d    = instr_q;
        data_d     = data_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pend_pc_d  = pend_pc_q;
        pend_vld_d = pend_vld_q;
`ifdef MISALIGN_TRAP_EN
        mis_d      = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (ir_write) begin
`ifdef MISALIGN_TRAP_EN
                    if (fetch_mis) begin
                        mis_d = 1'b1;
                    end else
`endif
                    begin
                        state_d    = FETCH_WAIT;
                        req_d      = 1'b1;
                        we_d       = 1'b0;
                        addr_d     = pc_q;
                        old_pc_d   = pc_q;
                        pend_vld_d = pc_update;
                        if (pc_update) pend_pc_d = pc_next;
                    end
                end else begin
                    if (data_read || mem_write) begin
`ifdef MISALIGN_TRAP_EN
                        if (data_mis) begin
                            mis_d = 1'b1;
                        end else
`endif
                        begin
                            state_d = data_read ? LOAD_WAIT : STORE_WAIT;
                            req_d   = 1'b1;
                            we_d    = ~data_read;
                            addr_d  = alu_out;
                            if (!data_read) wdata_d = store_data;
                        end
                    end
                    // PC commits immediately only when no fetch is being launched
                    if (pc_update || (branch && zero)) pc_d = pc_next;
                end
            end
            FETCH_WAIT, LOAD_WAIT, STORE_WAIT: begin
                if (mem.mem_ack) begin
                    if (state_q == FETCH_WAIT) begin
                        instr_d = mem.mem_rdata;
                        if (pend_vld_q) pc_d = pend_pc_q;
                        pend_vld_d = 1'b0;
                    end
                    if (state_q == LOAD_WAIT) data_d = mem.mem_rdata;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            old_pc_q   <= '0;
            instr_q    <= '0;
            data_q     <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            pend_pc_q  <= '0;
            pend_vld_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            old_pc_q   <= old_pc_d;
            instr_q    <= instr_d;
            data_q     <= data_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            pend_pc_q  <= pend_pc_d;
            pend_vld_q <= pend_vld_d;
`ifdef MISALIGN_TRAP_EN
            mis_q      <= mis_d;
`endif
        end
    end

    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign pc            = pc_q;
    assign old_pc        = old_pc_q;
    assign instr         = instr_q;
    assign opcode        = instr_q[6:0];
    assign data_reg      = data_q;
    assign busy          = (state_q != IDLE);
`ifdef MISALIGN_TRAP_EN
    assign misaligned    = mis_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch/load/store handshakes, branch qualification, mid-wait reset.
// Inputs change and outputs are sampled on the falling edge.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        ir_write, pc_update, branch, zero, data_read, mem_write;
    logic [31:0] pc_next, alu_out, store_data;
    logic [31:0] pc, old_pc, instr, data_reg;
    logic [6:0]  opcode;
    logic        busy;
`ifdef MISALIGN_TRAP_EN
    logic        misaligned;
`endif
    int checks = 0;
    int errors = 0;

    instr_fetch_unit_if #(.XLEN(32)) mif ();

    instr_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .ir_write   (ir_write),
        .pc_update  (pc_update),
        .branch     (branch),
        .zero       (zero),
        .data_read  (data_read),
        .mem_write  (mem_write),
        .pc_next    (pc_next),
        .alu_out    (alu_out),
        .store_data (store_data),
        .mem        (mif),
        .pc         (pc),
        .old_pc     (old_pc),
        .instr      (instr),
        .opcode     (opcode),
        .data_reg   (data_reg),
`ifdef MISALIGN_TRAP_EN
        .misaligned (misaligned),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        {ir_write, pc_update, branch, zero, data_read, mem_write} = '0;
        pc_next = '0; alu_out = '0; store_data = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        #12;
        chk("rst_pc", pc, 32'h0);
        chk("rst_old_pc", old_pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_data_reg", data_reg, 32'h0);
        chk("rst_req", {31'b0, mif.mem_req}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Fetch with pc_update, ack on the third cycle after req rises
        ir_write = 1'b1; pc_update = 1'b1; pc_next = 32'h4;
        tick();
        ir_write = 1'b0; pc_update = 1'b0; pc_next = 32'h0;
        for (int i = 0; i < 3; i++) begin
            chk("fetch_req", {31'b0, mif.mem_req}, 32'h1);
            chk("fetch_addr", mif.mem_addr, 32'h0);
            chk("fetch_busy", {31'b0, busy}, 32'h1);
            chk("fetch_pc_hold", pc, 32'h0);
            if (i == 2) begin
                mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0050_0093;
            end
            tick();
        end
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
        chk("fetch_instr", instr, 32'h0050_0093);
        chk("fetch_opcode", {25'b0, opcode}, 32'h13);
        chk("fetch_old_pc", old_pc, 32'h0);
        chk("fetch_pc", pc, 32'h4);
        chk("fetch_busy_fall", {31'b0, busy}, 32'h0);
        chk("fetch_req_fall", {31'b0, mif.mem_req}, 32'h0);

        // Load, 1-cycle latency
        data_read = 1'b1; alu_out = 32'h100;
        tick();
        data_read = 1'b0;
        chk("load_addr", mif.mem_addr, 32'h100);
        chk("load_we", {31'b0, mif.mem_we}, 32'h0);
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hDEAD_BEEF;
        tick();
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
        chk("load_data", data_reg, 32'hDEAD_BEEF);
        chk("load_pc", pc, 32'h4);
        chk("load_instr", instr, 32'h0050_0093);
        chk("load_busy", {31'b0, busy}, 32'h0);

        // Store, 2-cycle latency
        mem_write = 1'b1; alu_out = 32'h104; store_data = 32'h1234_5678;
        tick();
        mem_write = 1'b0; alu_out = 32'h0; store_data = 32'h0;
        for (int i = 0; i < 2; i++) begin
            chk("store_we", {31'b0, mif.mem_we}, 32'h1);
            chk("store_addr", mif.mem_addr, 32'h104);
            chk("store_wdata", mif.mem_wdata, 32'h1234_5678);
            chk("store_busy", {31'b0, busy}, 32'h1);
            if (i == 1) mif.mem_ack = 1'b1;
            tick();
        end
        mif.mem_ack = 1'b0;
        chk("store_busy_fall", {31'b0, busy}, 32'h0);
        chk("store_req_fall", {31'b0, mif.mem_req}, 32'h0);
        chk("store_data_reg", data_reg, 32'hDEAD_BEEF);

        // Branch qualification by zero
        branch = 1'b1; zero = 1'b0; pc_next = 32'h40;
        tick();
        chk("branch_nz_pc", pc, 32'h4);
        zero = 1'b1;
        tick();
        branch = 1'b0; zero = 1'b0;
        chk("branch_z_pc", pc, 32'h40);

        // Fetch from 0x40 with pending PC, strobes while busy, then reset mid-wait
        ir_write = 1'b1; pc_update = 1'b1; pc_next = 32'h44;
        tick();
        ir_write = 1'b0;
        pc_update = 1'b1; pc_next = 32'h80; data_read = 1'b1; alu_out = 32'h200;
        branch = 1'b1; zero = 1'b1;
        tick();
        {pc_update, data_read, branch, zero} = '0;
        chk("busy_addr", mif.mem_addr, 32'h40);
        chk("busy_we", {31'b0, mif.mem_we}, 32'h0);
        chk("busy_pc", pc, 32'h40);
        chk("busy_old_pc", old_pc, 32'h40);
        rst = 1'b1;
        #1;
        chk("midrst_req", {31'b0, mif.mem_req}, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
        tick();
        mif.mem_ack = 1'b0; mif.mem_rdata = 32'h0;
        chk("late_ack_instr", instr, 32'h0);
        chk("late_ack_pc", pc, 32'h0);
        chk("late_ack_busy", {31'b0, busy}, 32'h0);

        // Unaligned PC fetch
        pc_update = 1'b1; pc_next = 32'h2;
        tick();
        pc_update = 1'b0;
        chk("pc_load_2", pc, 32'h2);
        ir_write = 1'b1;
        tick();
        ir_write = 1'b0;
`ifdef MISALIGN_TRAP_EN
        chk("mis_req", {31'b0, mif.mem_req}, 32'h0);
        chk("mis_flag", {31'b0, misaligned}, 32'h1);
        chk("mis_pc", pc, 32'h2);
        chk("mis_old_pc", old_pc, 32'h0);
        tick();
        chk("mis_sticky", {31'b0, misaligned}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mis_rst", {31'b0, misaligned}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
`else
        chk("unal_req", {31'b0, mif.mem_req}, 32'h1);
        chk("unal_addr", mif.mem_addr, 32'h2);
        chk("unal_old_pc", old_pc, 32'h2);
        mif.mem_ack = 1'b1; mif.mem_rdata = 32'h0000_0073;
        tick();
        mif.mem_ack = 1'b0;
        chk("unal_opcode", {25'b0, opcode}, 32'h73);
        chk("unal_busy", {31'b0, busy}, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
